// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: FSM state codes, flag bit
// positions and the default debounce length.
package alu_pkg;

    localparam int unsigned DebNDefault = 50000;

    // State codes are visible on the STATE output, so the values are fixed.
    typedef enum logic [2:0] {
        StLdA   = 3'd0,
        StLdB   = 3'd1,
        StLdSel = 3'd2,
        StLdCi  = 3'd3,
        StExec  = 3'd4,
        StShow  = 3'd5
    } state_e;

    // Bit positions inside FLAGS_Q.
    localparam int unsigned FlagCo = 3;
    localparam int unsigned FlagOv = 2;
    localparam int unsigned FlagZ  = 1;
    localparam int unsigned FlagS  = 0;

    // Assemble the captured flag nibble from the individual ALU flags.
    function automatic logic [3:0] pack_flags(logic co, logic ov, logic z, logic s);
        logic [3:0] f;
        f         = 4'd0;
        f[FlagCo] = co;
        f[FlagOv] = ov;
        f[FlagZ]  = z;
        f[FlagS]  = s;
        return f;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop synchronizer, counter-based debounce and a
// registered one-cycle PRESS pulse on each debounced press.
module key_debounce
    import alu_pkg::*;
#(
    parameter int unsigned DEB_N = DebNDefault,
    parameter int unsigned CW    = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY,
    output logic PRESS
);

    localparam logic [CW-1:0] CntLast = CW'(DEB_N - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dly1_q, dly2_q;
    logic          press_q, press_d;

    // Debounce: count while the synchronized key disagrees, toggle on the last count
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CntLast) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Rising edge of the delayed debounced state; the extra delay stage fixes
    // press latency at DEB_N+3 edges from the first edge that samples KEY high.
    always_comb begin
        press_d = dly1_q & ~dly2_q;
    end

    // Synchronizer, debounce and pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
            dly1_q  <= 1'b0;
            dly2_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= KEY;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            dly1_q  <= deb_q;
            dly2_q  <= dly1_q;
            press_q <= press_d;
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Key-stepped operand entry for a 4-bit ALU: each debounced press loads SW
// into A, B, SEL and CI in turn, then the ALU result and flags are captured.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int unsigned DEB_N = DebNDefault,
    parameter int unsigned CW    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY,
    input  logic [3:0] SW,
    input  logic       ABORT,
    input  logic [3:0] R,
    input  logic       CO,
    input  logic       OV,
    input  logic       Z,
    input  logic       S,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] SEL,
    output logic       CI,
    output logic [3:0] R_Q,
    output logic [3:0] FLAGS_Q,
    output logic       VALID,
    output logic [2:0] STATE
);

    state_e     state_q, state_d;
    logic       press;
    logic [3:0] a_q, a_d, b_q, b_d, sel_q, sel_d;
    logic       ci_q, ci_d;
    logic [3:0] r_q, r_d, flags_q, flags_d;
    logic       valid_q, valid_d;

    key_debounce #(
        .DEB_N(DEB_N),
        .CW   (CW)
    ) u_key_debounce (
        .CLK  (CLK),
        .RST  (RST),
        .KEY  (KEY),
        .PRESS(press)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StLdA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: ABORT overrides everything, EXEC always advances after one cycle
    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = StLdA;
        end else begin
            case (state_q)
                StLdA:   if (press) state_d = StLdB;
                StLdB:   if (press) state_d = StLdSel;
                StLdSel: if (press) state_d = StLdCi;
                StLdCi:  if (press) state_d = StExec;
                StExec:  state_d = StShow;
                StShow:  if (press) state_d = StLdA;
                default: state_d = StLdA;
            endcase
        end
    end

    // Datapath loads, result capture and VALID, all decoded from the current state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        ci_d    = ci_q;
        r_d     = r_q;
        flags_d = flags_q;
        valid_d = 1'b0;
        if (ABORT) begin
            a_d   = 4'd0;
            b_d   = 4'd0;
            sel_d = 4'd0;
            ci_d  = 1'b0;
        end else begin
            case (state_q)
                StLdA:   if (press) a_d = SW;
                StLdB:   if (press) b_d = SW;
                StLdSel: if (press) sel_d = SW;
                StLdCi:  if (press) ci_d = SW[0];
                StExec: begin
                    r_d     = R;
                    flags_d = pack_flags(CO, OV, Z, S);
                    valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand, result and pulse registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            sel_q   <= 4'd0;
            ci_q    <= 1'b0;
            r_q     <= 4'd0;
            flags_q <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            ci_q    <= ci_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign SEL     = sel_q;
    assign CI      = ci_q;
    assign R_Q     = r_q;
    assign FLAGS_Q = flags_q;
    assign VALID   = valid_q;
    assign STATE   = state_q;

endmodule
